// File: rtl/axil_splitter_if.sv
// AXI4-Lite bundle, N lanes wide. Lane i of every signal sits at slice [i*W +: W].
// N=1 gives an ordinary single AXI4-Lite port.
interface axil_splitter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int N          = 1
);
  logic [N*ADDR_WIDTH-1:0]     awaddr;
  logic [N-1:0]                awvalid;
  logic [N-1:0]                awready;
  logic [N*DATA_WIDTH-1:0]     wdata;
  logic [N*(DATA_WIDTH/8)-1:0] wstrb;
  logic [N-1:0]                wvalid;
  logic [N-1:0]                wready;
  logic [N*2-1:0]              bresp;
  logic [N-1:0]                bvalid;
  logic [N-1:0]                bready;
  logic [N*ADDR_WIDTH-1:0]     araddr;
  logic [N-1:0]                arvalid;
  logic [N-1:0]                arready;
  logic [N*DATA_WIDTH-1:0]     rdata;
  logic [N*2-1:0]              rresp;
  logic [N-1:0]                rvalid;
  logic [N-1:0]                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_splitter.sv
// AXI4-Lite 1-to-NUM_M address splitter: one write and one read in flight, fully
// registered between upstream and downstream handshakes; unmapped regions get DECERR.
module axil_splitter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_M       = 2,
  parameter int REGION_BITS = 4
) (
  input  logic           s0_axi_aclk,
  input  logic           s0_axi_aresetn,
  axil_splitter_if.slave  s0,
  axil_splitter_if.master m
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SEL_W      = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_ISSUE = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;
  localparam logic [1:0] W_REPLY = 2'd3;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_ISSUE = 2'd1;
  localparam logic [1:0] R_WAIT  = 2'd2;
  localparam logic [1:0] R_REPLY = 2'd3;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic is_mapped(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> REGION_BITS) < ADDR_WIDTH'(NUM_M);
  endfunction

  function automatic logic [SEL_W-1:0] port_of(input logic [ADDR_WIDTH-1:0] addr);
    return SEL_W'(addr >> REGION_BITS);
  endfunction

  // ---------------------------------------------------------------- write path
  logic [1:0]            w_state;
  logic                  aw_done, w_done;
  logic                  aw_pend, w_pend;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [SEL_W-1:0]      w_sel;
  logic [1:0]            bresp_q;

  logic                  aw_fire, w_fire, m_aw_fire, m_w_fire;
  logic [ADDR_WIDTH-1:0] aw_addr_now;

  assign aw_fire     = s0.awvalid[0] && s0.awready[0];
  assign w_fire      = s0.wvalid[0] && s0.wready[0];
  assign m_aw_fire   = (w_state == W_ISSUE) && aw_pend && m.awready[w_sel];
  assign m_w_fire    = (w_state == W_ISSUE) && w_pend && m.wready[w_sel];
  assign aw_addr_now = aw_done ? awaddr_q : s0.awaddr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; later assignments in the same branch deliberately override earlier ones.
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      w_state  <= W_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      aw_pend  <= 1'b0;
      w_pend   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      w_sel    <= '0;
      bresp_q  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            awaddr_q <= s0.awaddr;
            aw_done  <= 1'b1;
          end
          if (w_fire) begin
            wdata_q <= s0.wdata;
            wstrb_q <= s0.wstrb;
            w_done  <= 1'b1;
          end
          // AW and W may arrive in either order; launch once both are held.
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (is_mapped(aw_addr_now)) begin
              w_sel   <= port_of(aw_addr_now);
              aw_pend <= 1'b1;
              w_pend  <= 1'b1;
              w_state <= W_ISSUE;
            end else begin
              bresp_q <= RESP_DECERR;
              w_state <= W_REPLY;
            end
          end
        end
        W_ISSUE: begin
          if (m_aw_fire) aw_pend <= 1'b0;
          if (m_w_fire)  w_pend  <= 1'b0;
          if ((!aw_pend || m_aw_fire) && (!w_pend || m_w_fire)) w_state <= W_RESP;
        end
        W_RESP: begin
          if (m.bvalid[w_sel]) begin
            bresp_q <= m.bresp[w_sel*2 +: 2];
            w_state <= W_REPLY;
          end
        end
        default: begin
          if (s0.bready[0]) w_state <= W_IDLE;
        end
      endcase
    end
  end

  // ----------------------------------------------------------------- read path
  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [SEL_W-1:0]      r_sel;
  logic                  ar_fire;

  assign ar_fire = s0.arvalid[0] && s0.arready[0];

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      r_state  <= R_IDLE;
      araddr_q <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      r_sel    <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            araddr_q <= s0.araddr;
            if (is_mapped(s0.araddr)) begin
              r_sel   <= port_of(s0.araddr);
              r_state <= R_ISSUE;
            end else begin
              rdata_q <= '0;
              rresp_q <= RESP_DECERR;
              r_state <= R_REPLY;
            end
          end
        end
        R_ISSUE: begin
          if (m.arready[r_sel]) r_state <= R_WAIT;
        end
        R_WAIT: begin
          if (m.rvalid[r_sel]) begin
            rdata_q <= m.rdata[r_sel*DATA_WIDTH +: DATA_WIDTH];
            rresp_q <= m.rresp[r_sel*2 +: 2];
            r_state <= R_REPLY;
          end
        end
        default: begin
          if (s0.rready[0]) r_state <= R_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------ outputs
  // Every valid/ready output is a function of registered state only. The IDLE
  // readies are also qualified by reset so they drop the instant reset asserts.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    s0.awready = s0_axi_aresetn && (w_state == W_IDLE) && !aw_done;
    s0.wready  = s0_axi_aresetn && (w_state == W_IDLE) && !w_done;
    s0.bvalid  = (w_state == W_REPLY);
    s0.bresp   = bresp_q;
    s0.arready = s0_axi_aresetn && (r_state == R_IDLE);
    s0.rvalid  = (r_state == R_REPLY);
    s0.rdata   = rdata_q;
    s0.rresp   = rresp_q;

    m.awaddr  = {NUM_M{awaddr_q}};
    m.wdata   = {NUM_M{wdata_q}};
    m.wstrb   = {NUM_M{wstrb_q}};
    m.araddr  = {NUM_M{araddr_q}};
    m.awvalid = '0;
    m.wvalid  = '0;
    m.bready  = '0;
    m.arvalid = '0;
    m.rready  = '0;

    m.awvalid[w_sel] = (w_state == W_ISSUE) && aw_pend;
    m.wvalid[w_sel]  = (w_state == W_ISSUE) && w_pend;
    m.bready[w_sel]  = (w_state == W_RESP);
    m.arvalid[r_sel] = (r_state == R_ISSUE);
    m.rready[r_sel]  = (r_state == R_WAIT);
  end

endmodule
